cordic_sequencer: RTL and testbench
===================================

Name: cordic_sequencer

Overview:
- Iterative controller that feeds and consumes one `cordic_core` instance. Each cycle it sends registered X/Y/beta/step to the core and captures the core's results.
- Accepts one angle per transaction and folds it into the core's convergence range ±pi/2.
- Seeds X with the CORDIC gain constant, so cos/sin come out unscaled.
- Runs STEPS iterations, then returns signed cos/sin over a valid/ready handshake.

Parameters:
- BITS, 16, data width; fixed point with 14 fractional bits (1.0 = 16384).
- STEPS, 14, CORDIC iterations; must equal the connected core's STEPS.
- K_INIT, 16'h26DD, initial X = 0.607253 * 16384 = 9949.
- PI_Q, 51472, pi in angle format.
- HALF_PI_Q, 25736, pi/2 in angle format.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  angle available.
- in_ready  out  1  sequencer can accept an angle.
- in_angle  in  BITS+1  signed angle, radians * 16384, legal range [-PI_Q, PI_Q].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- cos_out  out  BITS  signed cos * 16384.
- sin_out  out  BITS  signed sin * 16384.
- range_err  out  1  input angle was outside ±PI_Q and was clamped.
- core_x  out  BITS  to core Xin.
- core_y  out  BITS  to core Yin.
- core_b  out  BITS+1  to core Bin.
- core_step  out  $clog2(STEPS)  to core step.
- core_x_res  in  BITS  from core Xout.
- core_y_res  in  BITS  from core Yout.
- core_b_res  in  BITS+1  from core Bout.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; core_x/core_y/core_b/core_step/cos_out/sin_out=0; range_err=0; out_valid=0; internal negate flag=0. Reset overrides everything, including mid-RUN and DONE; the pending result is discarded.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered.
- IDLE, accept on in_valid && in_ready:
  - Clamp: angle > PI_Q -> PI_Q; angle < -PI_Q -> -PI_Q; range_err set if clamped, else cleared.
  - Fold: clamped > HALF_PI_Q -> B = angle - PI_Q, negate=1. Clamped < -HALF_PI_Q -> B = angle + PI_Q, negate=1. Otherwise B = angle, negate=0. Exactly ±HALF_PI_Q is not folded.
  - Load: core_x=K_INIT, core_y=0, core_b=B, core_step=0; go to RUN.
- RUN, every edge:
  - Capture core_x<=core_x_res, core_y<=core_y_res, core_b<=core_b_res.
  - If core_step==STEPS-1: go to DONE. cos_out = negate ? -core_x_res : core_x_res; sin_out likewise from core_y_res. Negation is two's complement, truncated to BITS.
  - Else core_step <= core_step+1.
- Latency: out_valid rises exactly STEPS edges after the accepting edge (14 by default).
- DONE: cos_out, sin_out and range_err held stable while out_valid=1 && out_ready=0. On out_ready=1 go to IDLE and clear out_valid. The next accept is possible one edge later, so minimum initiation interval is STEPS+2 cycles.
- in_valid during RUN/DONE is ignored (in_ready=0); no input buffering.
- out_ready while not in DONE has no effect.
- core_step never exceeds STEPS-1; the core's step_out is unused.

Test Plan:
- Reset then angle 0, out_ready=1 -> out_valid exactly 14 cycles after accept; cos_out=16384±16, sin_out=0±16, range_err=0.
- Angle 12868 (pi/4) -> cos_out=11585±16, sin_out=11585±16; in_ready=0 throughout RUN/DONE.
- Angle 25736 (boundary, unfolded) -> cos_out=0±16, sin_out=16384±16. Angle -38604 (-3pi/4, folded to 12868) -> cos_out=-11585±16, sin_out=-11585±16.
- Angle 60000 -> treated as PI_Q: cos_out=-16384±16, sin_out=0±16, range_err=1. Next angle 0 -> range_err=0.
- out_ready held 0 for 20 cycles after out_valid -> outputs and out_valid stable, in_ready=0; out_ready=1 -> one-cycle transfer, in_ready=1 next cycle.
- rst_n=0 for one edge at RUN step 5 -> next cycle state IDLE, out_valid=0, all outputs 0. A fresh angle 0 then completes normally in 14 cycles.

Source files
------------

// File: rtl/cordic_sequencer_if.sv
// Handshake and core-feed bundle of the CORDIC sequencer.
// slave = sequencer side, master = angle source / result sink / core model side.
interface cordic_sequencer_if #(
  parameter int BITS  = 16,
  parameter int STEPS = 14
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [BITS:0]   in_angle;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [BITS-1:0] cos_out;
  logic signed [BITS-1:0] sin_out;
  logic                   range_err;

  logic signed [BITS-1:0] core_x;
  logic signed [BITS-1:0] core_y;
  logic signed [BITS:0]   core_b;
  logic [SW-1:0]          core_step;
  logic signed [BITS-1:0] core_x_res;
  logic signed [BITS-1:0] core_y_res;
  logic signed [BITS:0]   core_b_res;

  modport slave (
    input  in_valid, in_angle, out_ready, core_x_res, core_y_res, core_b_res,
    output in_ready, out_valid, cos_out, sin_out, range_err,
           core_x, core_y, core_b, core_step
  );

  modport master (
    output in_valid, in_angle, out_ready, core_x_res, core_y_res, core_b_res,
    input  in_ready, out_valid, cos_out, sin_out, range_err,
           core_x, core_y, core_b, core_step
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC driver: clamps/folds one angle, runs STEPS core iterations, returns cos/sin.
// Result valid STEPS edges after accept; single transaction in flight, result held until out_ready.
module cordic_sequencer #(
  parameter int              BITS      = 16,
  parameter int              STEPS     = 14,
  parameter logic [BITS-1:0] K_INIT    = 16'h26DD,
  parameter int              PI_Q      = 51472,
  parameter int              HALF_PI_Q = 25736
) (
  input logic               clk,
  input logic               rst_n,
  cordic_sequencer_if.slave bus
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic signed [BITS:0] PI_A   = (BITS+1)'(PI_Q);
  localparam logic signed [BITS:0] HALF_A = (BITS+1)'(HALF_PI_Q);
  localparam logic [SW-1:0]        LAST   = SW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   in_ready;
  logic                   accept;
  logic                   last_step;

  logic signed [BITS-1:0] core_x_q, core_y_q;
  logic signed [BITS:0]   core_b_q;
  logic [SW-1:0]          step_q;
  logic signed [BITS-1:0] cos_q, sin_q;
  logic                   range_err_q;
  logic                   negate_q;
  logic                   out_valid_q;

  logic signed [BITS:0]   ang_clamp, ang_fold;
  logic                   clamped, fold;

  // Clamp to +-pi, then reflect through +-pi into the core's +-pi/2 range;
  // the reflection is undone by negating both results at the end.
  always_comb begin
    ang_clamp = bus.in_angle;
    clamped   = 1'b0;
    if (bus.in_angle > PI_A) begin
      ang_clamp = PI_A;
      clamped   = 1'b1;
    end else if (bus.in_angle < -PI_A) begin
      ang_clamp = -PI_A;
      clamped   = 1'b1;
    end

    ang_fold = ang_clamp;
    fold     = 1'b0;
    if (ang_clamp > HALF_A) begin
      ang_fold = ang_clamp - PI_A;
      fold     = 1'b1;
    end else if (ang_clamp < -HALF_A) begin
      ang_fold = ang_clamp + PI_A;
      fold     = 1'b1;
    end
  end

  assign last_step = (step_q == LAST);
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_x_q    <= '0;
      core_y_q    <= '0;
      core_b_q    <= '0;
      step_q      <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      range_err_q <= 1'b0;
      negate_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            range_err_q <= clamped;
            negate_q    <= fold;
            core_x_q    <= K_INIT;
            core_y_q    <= '0;
            core_b_q    <= ang_fold;
            step_q      <= '0;
          end
        end
        RUN: begin
          core_x_q <= bus.core_x_res;
          core_y_q <= bus.core_y_res;
          core_b_q <= bus.core_b_res;
          if (last_step) begin
            cos_q <= negate_q ? -bus.core_x_res : bus.core_x_res;
            sin_q <= negate_q ? -bus.core_y_res : bus.core_y_res;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;
  assign bus.range_err = range_err_q;
  assign bus.core_x    = core_x_q;
  assign bus.core_y    = core_y_q;
  assign bus.core_b    = core_b_q;
  assign bus.core_step = step_q;
endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: behavioural cordic_core, trig-based scoreboard, directed + random angles.
module tb_cordic_sequencer;
  localparam int BITS  = 16;
  localparam int STEPS = 14;
  localparam int PI_Q  = 51472;
  localparam int TOL   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cordic_sequencer_if #(.BITS(BITS), .STEPS(STEPS)) bus ();

  cordic_sequencer #(.BITS(BITS), .STEPS(STEPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One rotation-mode iteration of the external core.
  function automatic int atan_q(input logic [3:0] i);
    case (i)
      4'd0:    return 12868;
      4'd1:    return 7596;
      4'd2:    return 4014;
      4'd3:    return 2037;
      4'd4:    return 1023;
      4'd5:    return 512;
      4'd6:    return 256;
      4'd7:    return 128;
      4'd8:    return 64;
      4'd9:    return 32;
      4'd10:   return 16;
      4'd11:   return 8;
      4'd12:   return 4;
      4'd13:   return 2;
      default: return 1;
    endcase
  endfunction

  logic signed [BITS-1:0] xs, ys;
  int                     at;
  assign xs = bus.core_x >>> bus.core_step;
  assign ys = bus.core_y >>> bus.core_step;
  assign at = atan_q(bus.core_step);

  always_comb begin
    if (!bus.core_b[BITS]) begin
      bus.core_x_res = bus.core_x - ys;
      bus.core_y_res = bus.core_y + xs;
      bus.core_b_res = (BITS+1)'(int'(bus.core_b) - at);
    end else begin
      bus.core_x_res = bus.core_x + ys;
      bus.core_y_res = bus.core_y - xs;
      bus.core_b_res = (BITS+1)'(int'(bus.core_b) + at);
    end
  end

  typedef struct {
    real c;
    real s;
    bit  re;
    int  acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ordy_mode = 0;
  bit   mon_en = 0;
  bit   busy = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected result straight from trigonometry on the clamped angle.
  function automatic exp_t ref_model(input int a, input int acc);
    exp_t e;
    int   c;
    c    = a;
    e.re = 1'b0;
    if (c > PI_Q) begin
      c    = PI_Q;
      e.re = 1'b1;
    end else if (c < -PI_Q) begin
      c    = -PI_Q;
      e.re = 1'b1;
    end
    e.c   = 16384.0 * $cos(real'(c) / 16384.0);
    e.s   = 16384.0 * $sin(real'(c) / 16384.0);
    e.acc = acc;
    return e;
  endfunction

  function automatic bit near(input int act, input real req);
    real d;
    d = real'(act) - req;
    if (d < 0.0) d = -d;
    return d <= real'(TOL);
  endfunction

  // Monitor: in_ready vs. occupancy, out_valid protocol, result values, hold stability.
  bit   prev_ov = 0;
  bit   prev_xfer = 0;
  int   held_c, held_s;
  bit   held_re;
  exp_t e_cur;

  always @(negedge clk) begin
    int  cs, sn;
    bit  ov;
    if (mon_en && rst_n) begin
      ov = bus.out_valid;
      cs = int'(bus.cos_out);
      sn = int'(bus.sin_out);
      check("in_ready", bus.in_ready == !busy, bus.in_ready, !busy);
      if (prev_ov) check("out_valid_hold", ov == !prev_xfer, ov, !prev_xfer);
      if (ov && !prev_ov) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b0, 1, 0);
        end else begin
          e_cur = exp_q.pop_front();
          check("latency", cyc == e_cur.acc + STEPS, cyc - e_cur.acc, STEPS);
          check("cos_out", near(cs, e_cur.c), cs, $rtoi(e_cur.c));
          check("sin_out", near(sn, e_cur.s), sn, $rtoi(e_cur.s));
          check("range_err", bus.range_err == e_cur.re, bus.range_err, e_cur.re);
          held_c  = cs;
          held_s  = sn;
          held_re = bus.range_err;
        end
      end else if (ov) begin
        check("cos_stable", cs == held_c, cs, held_c);
        check("sin_stable", sn == held_s, sn, held_s);
        check("range_err_stable", bus.range_err == held_re, bus.range_err, held_re);
      end
      if (bus.in_valid && bus.in_ready) busy = 1'b1;
      if (ov && bus.out_ready) busy = 1'b0;
      prev_ov   = ov;
      prev_xfer = ov && bus.out_ready;
    end else begin
      prev_ov   = 1'b0;
      prev_xfer = 1'b0;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Waits for in_ready (tossing ignored junk at the busy DUT), then presents the angle for one edge.
  task automatic send(input int a);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!bus.in_ready && n < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b1;
        bus.in_angle = (BITS+1)'($urandom_range(0, 131071));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 1'b0, n, 200);
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_angle = (BITS+1)'(a);
    exp_q.push_back(ref_model(a, cyc + 1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", !busy && exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_out_valid"}, bus.out_valid == 1'b0, bus.out_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready == 1'b1, bus.in_ready, 1);
    check({tag, "_cos"}, bus.cos_out == '0, bus.cos_out, 0);
    check({tag, "_sin"}, bus.sin_out == '0, bus.sin_out, 0);
    check({tag, "_range_err"}, bus.range_err == 1'b0, bus.range_err, 0);
    check({tag, "_core_x"}, bus.core_x == '0, bus.core_x, 0);
    check({tag, "_core_y"}, bus.core_y == '0, bus.core_y, 0);
    check({tag, "_core_b"}, bus.core_b == '0, bus.core_b, 0);
    check({tag, "_core_step"}, bus.core_step == '0, bus.core_step, 0);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_state("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    send(0);
    wait_idle();
    send(12868);
    wait_idle();
    send(25736);
    send(-38604);
    send(60000);
    send(0);
    send(-60000);
    send(-25736);
    wait_idle();

    // Consumer stalls for 20 cycles after the result appears.
    ordy_mode = 2;
    send(12868);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait", bus.out_valid == 1'b1, bus.out_valid, 1);
    repeat (20) @(negedge clk);
    check("stall_out_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
    check("stall_in_ready", bus.in_ready == 1'b0, bus.in_ready, 0);
    ordy_mode = 0;
    wait_idle();

    // Reset lands while the core is on step 5; the pending result is dropped.
    send(60000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    busy = 1'b0;
    @(posedge clk);
    #1;
    check_zero_state("midrun_reset");
    rst_n = 1'b1;
    send(0);
    wait_idle();

    ordy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 131071)) - 65536);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "global timeout");
  end
endmodule
